nano_cpu_param: RTL and testbench
=================================

// Module: nano_cpu_param
// PURPOSE
//  Parametrised multi-cycle accumulator-free load/store CPU, successor of the 4-register 16-bit NanoCPU.
//  Generalised register count/data width; adds memory req/ack handshake (wait states), register-conditional
//  branch, retire/halt/illegal status. Sits between a single-port program/data memory and the test harness.
// PARAMETERS
//  DATA_W  16  datapath/register width; legal >= 16 (instruction = mem_rdata[15:0])
//  NREGS   4   general registers; power of 2, 2..16; index = low $clog2(NREGS) bits of a 4-bit field
//  ADDR_W  8   PC / memory address width; legal 4..8; 8-bit address fields truncated to ADDR_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  mem_req    out  1       memory request; held until mem_ack
//  mem_we     out  1       1 = write request (valid with mem_req)
//  mem_addr   out  ADDR_W  address (PC in FETCH, IR[7:0] in MEM_RD/MEM_WR)
//  mem_wdata  out  DATA_W  store data = reg[IR[11:8]]
//  mem_rdata  in   DATA_W  read data, sampled in the cycle mem_ack=1
//  mem_ack    in   1       completes current request same cycle; ignored when mem_req=0
//  retire     out  1       1-cycle pulse when an instruction completes (PC update cycle)
//  halted     out  1       1 while in HALT
//  illegal    out  1       sticky; set when HALT entered via undefined opcode
//  pc_out     out  ADDR_W  current PC
// BEHAVIOUR
//  Reset: all regs, PC, IR = 0; state IDLE; mem_req/mem_we/retire/halted/illegal = 0. Mid-op reset aborts
//   any outstanding request immediately (mem_req drops asynchronously).
//  Encoding: op=IR[15:12], rd=IR[11:8], rs1=IR[7:4], rs2=IR[3:0], a8=IR[7:0].
//   0 READ rd<=mem[a8] | 1 WRITE mem[a8]<=rd | 2 JMP PC<=a8 | 3 BRANCH PC<=(rd!=0)?a8:PC+1
//   4 XOR 5 SUB 6 ADD 7 LESS(unsigned, result 1/0) rd<=rs1 op rs2 | 8 MUL (macro) | F END | others illegal
//  FSM: IDLE->FETCH (1 cycle). FETCH: req, we=0, addr=PC; on ack IR<=rdata[15:0], ->DECODE.
//   DECODE->MEM_RD|MEM_WR|ALU|JMP|BRANCH|HALT by opcode. MEM_RD/MEM_WR: req until ack, then write rd
//   (RD) and PC<=PC+1. ALU/JMP/BRANCH: single cycle, PC update. All completions ->FETCH with retire=1.
//   HALT: terminal until rst; no requests; retire not pulsed for END.
//  Latency, zero-wait memory (ack same cycle): ALU/JMP/BRANCH 3 cycles, READ/WRITE 4; each wait cycle +1.
//  mem_addr/mem_we/mem_wdata stable while mem_req=1 and ack=0.
//  Arithmetic modulo 2^DATA_W; SUB wraps (0-1 = all ones). rd==rs allowed: read old value, write at edge.
//  PC wraps 2^ADDR_W-1 -> 0; jump/branch targets truncated to ADDR_W bits.
// CONFIGURATION
//  NANO_CPU_MUL_EN defined: op 8 = MUL, rd <= low DATA_W bits of rs1*rs2, ALU timing.
//  Not defined: op 8 is illegal -> HALT, illegal=1.
// STRUCTURE
//  Package nano_cpu_pkg: opcode_t enum (4-bit), state_t enum, field position localparams (OP_HI/LO etc.).
//  Sub-module nano_regfile #(DATA_W,NREGS): 2 async read ports, 1 sync write port, async reset to 0.
//  Top holds FSM, IR/PC, ALU (always_comb case on opcode), handshake outputs.
// TESTING
//  1 Zero-wait: prog READ r1,[0x10](=5); READ r2,[0x11](=3); SUB r3,r1,r2; WRITE r3,[0x12]; END
//    -> mem[0x12]=2, halted=1, illegal=0, 4 retire pulses, total 19 cycles after IDLE.
//  2 Wait states: ack delayed 3 cycles per request -> same results; addr/we/wdata stable during waits.
//  3 Branch/loop: r1=3, r2=1; loop SUB r1,r1,r2; BRANCH r1,loop; END -> body 3x, r1=0, PC at END.
//  4 Wrap: ADD with 0xFFFF+1 (DATA_W=16) -> 0; LESS 2<0xFFFF -> 1; JMP 0xFF with ADDR_W=4 -> PC=0xF, then 0.
//  5 Illegal: opcode 0x9 -> halted=1, illegal=1, mem_req stays 0; opcode 8 same unless NANO_CPU_MUL_EN
//    (then 7*6 -> 42).
//  6 Reset mid-MEM_WR with ack withheld -> mem_req=0 at once, PC=0, regs=0, restart fetches address 0.

Source files
------------

// File: rtl/nano_cpu_pkg.sv
// Shared opcodes, FSM states and instruction field positions for nano_cpu_param.
// Optional multiply opcode is enabled by defining NANO_CPU_MUL_EN.
package nano_cpu_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int A8_HI  = 7;
  localparam int A8_LO  = 0;

  typedef enum logic [3:0] {
    OP_READ   = 4'h0,
    OP_WRITE  = 4'h1,
    OP_JMP    = 4'h2,
    OP_BRANCH = 4'h3,
    OP_XOR    = 4'h4,
    OP_SUB    = 4'h5,
    OP_ADD    = 4'h6,
    OP_LESS   = 4'h7,
    OP_MUL    = 4'h8,
    OP_END    = 4'hF
  } opcode_t;

  // MEM_DONE is the shared completion cycle of READ/WRITE: it commits rd and the PC.
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_DONE,
    S_ALU,
    S_JMP,
    S_BRANCH,
    S_HALT
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    logic res;
    res = (op == OP_XOR) || (op == OP_SUB) || (op == OP_ADD) || (op == OP_LESS);
`ifdef NANO_CPU_MUL_EN
    res = res || (op == OP_MUL);
`endif
    return res;
  endfunction

endpackage

// File: rtl/nano_cpu_param_regfile.sv
// General register file: two asynchronous read ports, one synchronous write port,
// asynchronous reset of every register to zero.
module nano_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        ra_data,
  output logic [DATA_W-1:0]        rb_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/nano_cpu_param.sv
// Parametrised multi-cycle load/store CPU with req/ack memory handshake.
// Define NANO_CPU_MUL_EN to make opcode 8 a multiply; otherwise it halts as illegal.
module nano_cpu_param
  import nano_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int IDX_W = $clog2(NREGS);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] mdr;
  logic              illegal_q;

  logic [3:0]        op;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rs1_idx;
  logic [IDX_W-1:0]  rs2_idx;
  logic [ADDR_W-1:0] a8;

  logic [IDX_W-1:0]  ra_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_res;

  // Register indices use only the low bits of each 4-bit field; the rest is ignored.
  logic              unused_ir;
  assign unused_ir = ^ir;

  assign op      = ir[OP_HI:OP_LO];
  assign rd_idx  = ir[RD_LO +: IDX_W];
  assign rs1_idx = ir[RS1_LO +: IDX_W];
  assign rs2_idx = ir[RS2_LO +: IDX_W];
  assign a8      = ir[A8_LO +: ADDR_W];
  assign pc_inc  = pc + ADDR_W'(1);

  // Port A serves rs1 for ALU ops and rd otherwise (store data, branch condition).
  assign ra_addr = is_alu_op(op) ? rs1_idx : rd_idx;

  nano_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ra_addr),
    .rb_addr (rs2_idx),
    .wr_en   (rf_we),
    .wr_addr (rd_idx),
    .wr_data (rf_wdata),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_XOR:  alu_res = ra_data ^ rb_data;
      OP_SUB:  alu_res = ra_data - rb_data;
      OP_ADD:  alu_res = ra_data + rb_data;
      OP_LESS: alu_res = DATA_W'(ra_data < rb_data);
`ifdef NANO_CPU_MUL_EN
      OP_MUL:  alu_res = ra_data * rb_data;
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs decode straight from the state so reset drops mem_req at once.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    retire    = 1'b0;
    halted    = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_res;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_READ:   state_nxt = S_MEM_RD;
          OP_WRITE:  state_nxt = S_MEM_WR;
          OP_JMP:    state_nxt = S_JMP;
          OP_BRANCH: state_nxt = S_BRANCH;
          OP_END:    state_nxt = S_HALT;
          default:   state_nxt = is_alu_op(op) ? S_ALU : S_HALT;
        endcase
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = a8;
        if (mem_ack) state_nxt = S_MEM_DONE;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = a8;
        if (mem_ack) state_nxt = S_MEM_DONE;
      end
      S_MEM_DONE: begin
        retire    = 1'b1;
        rf_we     = (op == OP_READ);
        rf_wdata  = mdr;
        state_nxt = S_FETCH;
      end
      S_ALU: begin
        retire    = 1'b1;
        rf_we     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JMP, S_BRANCH: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ack) ir <= mem_rdata[15:0];
        S_DECODE:   if (state_nxt == S_HALT && op != OP_END) illegal_q <= 1'b1;
        S_MEM_RD:   if (mem_ack) mdr <= mem_rdata;
        S_MEM_DONE: pc <= pc_inc;
        S_ALU:      pc <= pc_inc;
        S_JMP:      pc <= a8;
        S_BRANCH:   pc <= (ra_data != '0) ? a8 : pc_inc;
        default:    ;
      endcase
    end
  end

  assign mem_wdata = ra_data;
  assign illegal   = illegal_q;
  assign pc_out    = pc;

endmodule

// File: tb/tb_nano_cpu_param.sv
// Scoreboard bench for nano_cpu_param: directed programs, a memory responder with
// configurable wait states, and a monitor that checks every acknowledged store.
module tb_nano_cpu_param;
  import nano_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        retire;
  logic        halted;
  logic        illegal;
  logic [7:0]  pc_out;

  always #5 clk = ~clk;

  nano_cpu_param #(.DATA_W(16), .NREGS(4), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal),
    .pc_out    (pc_out)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] mem [256];
  wr_t         exp_q[$];
  int          wait_states = 0;
  int          wait_cnt = 0;
  logic        hold_en = 1'b0;
  logic [7:0]  hold_addr = '0;
  int          checks = 0;
  int          errors = 0;
  int          retire_cnt = 0;
  int          stab_err = 0;
  logic        cap_valid = 1'b0;
  logic [7:0]  cap_addr;
  logic        cap_we;
  logic [15:0] cap_wdata;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] a, input logic [3:0] b);
    return {op, rd, a, b};
  endfunction

  function automatic logic [15:0] enc8(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [7:0] a8);
    return {op, rd, a8};
  endfunction

  // Memory responder: acks after wait_states idle cycles, optionally withholds a store.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !rst) begin
      if (hold_en && mem_we && mem_addr == hold_addr) begin
        mem_ack = 1'b0;
      end else if (wait_cnt < wait_states) begin
        wait_cnt++;
      end else begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: counts retires, tracks request stability, pops expected stores.
  always @(negedge clk) begin
    #1;
    if (retire) retire_cnt++;
    if (mem_req) begin
      if (cap_valid && (mem_addr != cap_addr || mem_we != cap_we ||
                        (mem_we && mem_wdata != cap_wdata)))
        stab_err++;
      if (!cap_valid) begin
        cap_valid = 1'b1;
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end
      if (mem_ack) begin
        cap_valid = 1'b0;
        if (mem_we) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL store_unexpected: got addr %0h data %0h, required none", mem_addr, mem_wdata);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr != e.addr || mem_wdata != e.data) begin
              errors++;
              $display("[TB] FAIL store: got addr %0h data %0h, required addr %0h data %0h",
                       mem_addr, mem_wdata, e.addr, e.data);
            end
          end
        end
      end
    end else begin
      cap_valid = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic expectStore(input logic [7:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic runToHalt(output int cycles);
    cycles = 0;
    while (!halted && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      #2;
    end
    checkOutput("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  task automatic applyStimulus(input int waits, output int cycles);
    wait_states = waits;
    hold_en = 1'b0;
    stab_err = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    retire_cnt = 0;
    rst = 1'b0;
    runToHalt(cycles);
  endtask

  task automatic endChecks(input string tag, input int retires, input logic [7:0] pc,
                           input logic ill);
    checkOutput({tag, "_retires"}, retire_cnt, retires);
    checkOutput({tag, "_pc"}, {24'b0, pc_out}, {24'b0, pc});
    checkOutput({tag, "_illegal"}, {31'b0, illegal}, {31'b0, ill});
    checkOutput({tag, "_stores_left"}, exp_q.size(), 0);
    checkOutput({tag, "_stable"}, stab_err, 0);
  endtask

  task automatic loadSubProgram();
    clearMem();
    mem[8'h00] = enc8(OP_READ, 4'h1, 8'h10);
    mem[8'h01] = enc8(OP_READ, 4'h2, 8'h11);
    mem[8'h02] = enc(OP_SUB, 4'h3, 4'h1, 4'h2);
    mem[8'h03] = enc8(OP_WRITE, 4'h3, 8'h12);
    mem[8'h04] = 16'hF000;
    mem[8'h10] = 16'd5;
    mem[8'h11] = 16'd3;
    expectStore(8'h12, 16'd2);
  endtask

  initial begin
    int cycles;
    int reqs;
    int seen;

    $display("[TB] nano_cpu_param scoreboard bench");
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_req", {31'b0, mem_req}, 0);
    checkOutput("reset_halted", {31'b0, halted}, 0);
    checkOutput("reset_illegal", {31'b0, illegal}, 0);
    checkOutput("reset_retire", {31'b0, retire}, 0);
    checkOutput("reset_pc", {24'b0, pc_out}, 0);

    // Zero-wait: halted is visible in the 19th cycle counting IDLE as the first.
    loadSubProgram();
    applyStimulus(0, cycles);
    checkOutput("t1_cycles", cycles, 18);
    checkOutput("t1_mem12", {16'b0, mem[8'h12]}, 32'd2);
    endChecks("t1", 4, 8'h04, 1'b0);

    // Three wait cycles on each of the eight requests.
    loadSubProgram();
    applyStimulus(3, cycles);
    checkOutput("t2_cycles", cycles, 42);
    checkOutput("t2_mem12", {16'b0, mem[8'h12]}, 32'd2);
    endChecks("t2", 4, 8'h04, 1'b0);

    // Count-down loop with a store per iteration.
    clearMem();
    mem[8'h00] = enc8(OP_READ, 4'h1, 8'h10);
    mem[8'h01] = enc8(OP_READ, 4'h2, 8'h11);
    mem[8'h02] = enc(OP_SUB, 4'h1, 4'h1, 4'h2);
    mem[8'h03] = enc8(OP_WRITE, 4'h1, 8'h20);
    mem[8'h04] = enc8(OP_BRANCH, 4'h1, 8'h02);
    mem[8'h05] = 16'hF000;
    mem[8'h10] = 16'd3;
    mem[8'h11] = 16'd1;
    expectStore(8'h20, 16'd2);
    expectStore(8'h20, 16'd1);
    expectStore(8'h20, 16'd0);
    applyStimulus(1, cycles);
    endChecks("t3", 11, 8'h05, 1'b0);

    // Wrapping arithmetic, unsigned compare, rd aliasing a source.
    clearMem();
    mem[8'h00] = enc8(OP_READ, 4'h1, 8'h40);
    mem[8'h01] = enc8(OP_READ, 4'h2, 8'h41);
    mem[8'h02] = enc(OP_ADD, 4'h3, 4'h1, 4'h2);
    mem[8'h03] = enc8(OP_WRITE, 4'h3, 8'h50);
    mem[8'h04] = enc8(OP_READ, 4'h2, 8'h42);
    mem[8'h05] = enc(OP_LESS, 4'h3, 4'h2, 4'h1);
    mem[8'h06] = enc8(OP_WRITE, 4'h3, 8'h51);
    mem[8'h07] = enc(OP_LESS, 4'h3, 4'h1, 4'h2);
    mem[8'h08] = enc8(OP_WRITE, 4'h3, 8'h52);
    mem[8'h09] = enc(OP_SUB, 4'h2, 4'h0, 4'h2);
    mem[8'h0A] = enc8(OP_WRITE, 4'h2, 8'h53);
    mem[8'h0B] = enc(OP_XOR, 4'h2, 4'h2, 4'h1);
    mem[8'h0C] = enc8(OP_WRITE, 4'h2, 8'h54);
    mem[8'h0D] = 16'hF000;
    mem[8'h40] = 16'hFFFF;
    mem[8'h41] = 16'h0001;
    mem[8'h42] = 16'h0002;
    expectStore(8'h50, 16'h0000);
    expectStore(8'h51, 16'h0001);
    expectStore(8'h52, 16'h0000);
    expectStore(8'h53, 16'hFFFE);
    expectStore(8'h54, 16'h0001);
    applyStimulus(0, cycles);
    endChecks("t4", 13, 8'h0D, 1'b0);

    // PC wrap: jump to 0xFF, store an END over address 0, wrap and halt there.
    clearMem();
    mem[8'h00] = enc8(OP_READ, 4'h3, 8'h40);
    mem[8'h01] = enc8(OP_JMP, 4'h0, 8'hFF);
    mem[8'hFF] = enc8(OP_WRITE, 4'h3, 8'h00);
    mem[8'h40] = 16'hF000;
    expectStore(8'h00, 16'hF000);
    applyStimulus(0, cycles);
    endChecks("t4w", 3, 8'h00, 1'b0);

    // Undefined opcode 9 halts immediately with illegal set and no further requests.
    clearMem();
    mem[8'h00] = 16'h9000;
    applyStimulus(0, cycles);
    checkOutput("t5_cycles", cycles, 3);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (mem_req) reqs++;
    end
    checkOutput("t5_halt_no_req", reqs, 0);
    endChecks("t5", 0, 8'h00, 1'b1);

    // Opcode 8: multiply when enabled, otherwise illegal at PC 2.
    clearMem();
    mem[8'h00] = enc8(OP_READ, 4'h1, 8'h10);
    mem[8'h01] = enc8(OP_READ, 4'h2, 8'h11);
    mem[8'h02] = enc(OP_MUL, 4'h3, 4'h1, 4'h2);
    mem[8'h03] = enc8(OP_WRITE, 4'h3, 8'h12);
    mem[8'h04] = 16'hF000;
    mem[8'h10] = 16'd7;
    mem[8'h11] = 16'd6;
`ifdef NANO_CPU_MUL_EN
    expectStore(8'h12, 16'd42);
    applyStimulus(0, cycles);
    endChecks("t5m", 4, 8'h04, 1'b0);
`else
    applyStimulus(0, cycles);
    endChecks("t5m", 2, 8'h02, 1'b1);
`endif

    // Reset while a store is stalled; registers must be cleared for the rerun.
    clearMem();
    mem[8'h00] = enc8(OP_BRANCH, 4'h1, 8'h03);
    mem[8'h01] = enc8(OP_READ, 4'h1, 8'h10);
    mem[8'h02] = enc8(OP_WRITE, 4'h1, 8'h30);
    mem[8'h03] = enc8(OP_WRITE, 4'h1, 8'h31);
    mem[8'h04] = 16'hF000;
    mem[8'h10] = 16'd9;
    wait_states = 0;
    stab_err = 0;
    hold_en = 1'b1;
    hold_addr = 8'h30;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      #2;
      if (mem_req && mem_we) seen = 1;
    end
    checkOutput("t6_store_stalled", seen, 1);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("t6_still_req", {31'b0, mem_req}, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_req_drop", {31'b0, mem_req}, 0);
    checkOutput("t6_pc_reset", {24'b0, pc_out}, 0);
    hold_en = 1'b0;
    expectStore(8'h30, 16'd9);
    expectStore(8'h31, 16'd9);
    @(negedge clk);
    retire_cnt = 0;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      #2;
      if (mem_req) seen = 1;
    end
    checkOutput("t6_refetch_seen", seen, 1);
    checkOutput("t6_refetch_addr", {24'b0, mem_addr}, 0);
    checkOutput("t6_refetch_we", {31'b0, mem_we}, 0);
    runToHalt(cycles);
    endChecks("t6", 4, 8'h04, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
